// File: rtl/dlx_fetch_stage_pkg.sv
// Shared DLX fetch definitions: opcode encodings, bubble/trap words and
// immediate sign-extension helpers used by the fetch stage and its redirect unit.
package dlx_fetch_stage_pkg;

    typedef logic [5:0] opcode_t;

    localparam opcode_t OP_J    = 6'h02;
    localparam opcode_t OP_JAL  = 6'h03;
    localparam opcode_t OP_BEQZ = 6'h04;
    localparam opcode_t OP_BNEZ = 6'h05;
    localparam opcode_t OP_JR   = 6'h12;
    localparam opcode_t OP_JALR = 6'h13;

    localparam logic [31:0] DLX_NOP_WORD  = 32'h5400_0000;
    localparam logic [31:0] DLX_HALT_WORD = 32'h4400_0300;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    function automatic logic [31:0] sext26(input logic [25:0] imm);
        return {{6{imm[25]}}, imm};
    endfunction

endpackage

// File: rtl/dlx_redirect_unit.sv
// Combinational branch/jump resolution for the instruction sitting in ID.
// Instruction bits use DLX big-endian numbering: opcode [0:5], imm26 [6:31], imm16 [16:31].
module dlx_redirect_unit
    import dlx_fetch_stage_pkg::*;
(
    input  logic [0:31] instr_i,
    input  logic [31:0] pc_plus4_i,
    input  logic        rs1_zero_i,
    input  logic [31:0] rs1_val_i,
    output logic        taken_o,
    output logic [31:0] target_o
);

    opcode_t     opcode;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] raw_target;

    always_comb begin
        opcode     = instr_i[0:5];
        imm16      = instr_i[16:31];
        imm26      = instr_i[6:31];
        taken_o    = 1'b0;
        raw_target = pc_plus4_i + sext16(imm16);
        case (opcode)
            OP_BEQZ: taken_o = rs1_zero_i;
            OP_BNEZ: taken_o = ~rs1_zero_i;
            OP_J, OP_JAL: begin
                taken_o    = 1'b1;
                raw_target = pc_plus4_i + sext26(imm26);
            end
            OP_JR, OP_JALR: begin
                taken_o    = 1'b1;
                raw_target = rs1_val_i;
            end
            default: taken_o = 1'b0;
        endcase
        // Fetch is word-aligned; low target bits are discarded, not trapped.
        target_o = {raw_target[31:2], 2'b00};
    end

endmodule

// File: rtl/dlx_fetch_stage.sv
// DLX instruction-fetch stage: PC register, IF/ID pipeline register and sticky
// trap-halt flag, with ID-stage branch/jump redirect (one bubble on taken).
module dlx_fetch_stage
    import dlx_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR  = DLX_NOP_WORD,
    parameter logic [31:0] HALT_INSTR = DLX_HALT_WORD
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [0:31] imem_data,
    input  logic        stall,
    input  logic        rs1_zero,
    input  logic [31:0] rs1_val,
    output logic [0:31] instr_id,
    output logic [31:0] pc_id,
    output logic [31:0] pc_plus4_id,
    output logic        valid_id,
    output logic        redirect,
    output logic        halted
);

    logic [31:0] pc_q, pc_d;
    logic [0:31] instr_q, instr_d;
    logic [31:0] pc_id_q, pc_id_d;
    logic [31:0] pc4_id_q, pc4_id_d;
    logic        valid_q, valid_d;
    logic        halted_q, halted_d;

    logic        taken;
    logic [31:0] target;
    logic        halt_detect;

    dlx_redirect_unit u_redirect (
        .instr_i    (instr_q),
        .pc_plus4_i (pc4_id_q),
        .rs1_zero_i (rs1_zero),
        .rs1_val_i  (rs1_val),
        .taken_o    (taken),
        .target_o   (target)
    );

    assign halt_detect = valid_q && !stall && !halted_q && (instr_q == HALT_INSTR);
    // Operands are only trustworthy when the hazard unit is not stalling.
    assign redirect    = taken && valid_q && !stall && !halted_q && !halt_detect;

    always_comb begin
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc_id_d  = pc_id_q;
        pc4_id_d = pc4_id_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        if (halted_q || stall) begin
            pc_d = pc_q;
        end else if (halt_detect) begin
            halted_d = 1'b1;
            instr_d  = NOP_INSTR;
            valid_d  = 1'b0;
        end else if (redirect) begin
            pc_d     = target;
            instr_d  = NOP_INSTR;
            pc_id_d  = pc_q;
            pc4_id_d = pc_q + 32'd4;
            valid_d  = 1'b0;
        end else begin
            pc_d     = pc_q + 32'd4;
            instr_d  = imem_data;
            pc_id_d  = pc_q;
            pc4_id_d = pc_q + 32'd4;
            valid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            instr_q  <= NOP_INSTR;
            pc_id_q  <= 32'd0;
            pc4_id_q <= 32'd0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_id_q  <= pc_id_d;
            pc4_id_q <= pc4_id_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    assign imem_addr   = pc_q;
    assign instr_id    = instr_q;
    assign pc_id       = pc_id_q;
    assign pc_plus4_id = pc4_id_q;
    assign valid_id    = valid_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_dlx_fetch_stage.sv
// Bench for dlx_fetch_stage: directed programs plus randomized programs and
// hazard/reset stimulus, compared every cycle against an instruction-level model.
module tb_dlx_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_W    = 32'h5400_0000;
    localparam logic [31:0] HALT_W   = 32'h4400_0300;

    logic        clk = 1'b0;
    logic        reset, stall, rs1_zero;
    logic [31:0] rs1_val, imem_addr, pc_id, pc_plus4_id;
    logic [0:31] imem_data, instr_id;
    logic        valid_id, redirect, halted;

    logic [31:0] mem [256];

    // Model state
    logic [31:0] m_pc, m_instr, m_pcid, m_pc4;
    logic        m_valid, m_halted, m_ids_known;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dlx_fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .stall       (stall),
        .rs1_zero    (rs1_zero),
        .rs1_val     (rs1_val),
        .instr_id    (instr_id),
        .pc_id       (pc_id),
        .pc_plus4_id (pc_plus4_id),
        .valid_id    (valid_id),
        .redirect    (redirect),
        .halted      (halted)
    );

    function automatic logic [31:0] fetch_word(input logic [31:0] a);
        if (a < 32'd1024) return mem[a[9:2]];
        return {16'h2000, a[15:0]};
    endfunction

    assign imem_data = fetch_word(imem_addr);

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Branch/jump semantics written directly from the ISA rules.
    task automatic model_branch(output logic tk, output logic [31:0] tgt);
        int unsigned op;
        logic [31:0] base;
        op   = m_instr >> 26;
        base = m_pcid + 32'd4;
        tk   = 1'b0;
        tgt  = 32'd0;
        case (op)
            4:  begin tk = rs1_zero;  tgt = base + 32'($signed(m_instr[15:0])); end
            5:  begin tk = !rs1_zero; tgt = base + 32'($signed(m_instr[15:0])); end
            2, 3: begin tk = 1'b1;    tgt = base + 32'($signed(m_instr[25:0])); end
            18, 19: begin tk = 1'b1;  tgt = rs1_val; end
            default: tk = 1'b0;
        endcase
        tgt = (tgt / 4) * 4;
    endtask

    task automatic check_outputs();
        logic        tk;
        logic [31:0] tgt;
        logic        exp_redirect;
        model_branch(tk, tgt);
        exp_redirect = m_valid && !stall && !m_halted && (m_instr != HALT_W) && tk;
        check_val("imem_addr", imem_addr, m_pc);
        check_val("instr_id", instr_id, m_instr);
        check_val("valid_id", {31'd0, valid_id}, {31'd0, m_valid});
        check_val("halted", {31'd0, halted}, {31'd0, m_halted});
        check_val("redirect", {31'd0, redirect}, {31'd0, exp_redirect});
        if (m_ids_known) begin
            check_val("pc_id", pc_id, m_pcid);
            check_val("pc_plus4_id", pc_plus4_id, m_pc4);
        end
    endtask

    task automatic model_step();
        logic        tk;
        logic [31:0] tgt;
        model_branch(tk, tgt);
        if (reset) begin
            m_pc = RESET_PC; m_instr = NOP_W; m_pcid = 0; m_pc4 = 0;
            m_valid = 0; m_halted = 0; m_ids_known = 1;
        end else if (m_halted || stall) begin
            m_pc = m_pc;
        end else if (m_valid && m_instr == HALT_W) begin
            m_halted = 1; m_instr = NOP_W; m_valid = 0; m_ids_known = 0;
        end else if (m_valid && tk) begin
            m_pc = tgt; m_instr = NOP_W; m_valid = 0; m_ids_known = 0;
        end else begin
            m_instr = fetch_word(m_pc); m_pcid = m_pc; m_pc4 = m_pc + 4;
            m_valid = 1; m_ids_known = 1; m_pc = m_pc + 4;
        end
    endtask

    // Called one time unit after a rising edge; returns at the same phase.
    task automatic cycle(input logic rst, input logic st, input logic rz, input logic [31:0] rv);
        reset = rst; stall = st; rs1_zero = rz; rs1_val = rv;
        #4;
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'h2000_0000 | 32'(i);
    endtask

    function automatic logic [31:0] rand_instr();
        int r, off;
        logic [31:0] w;
        r   = $urandom_range(0, 99);
        off = $urandom_range(0, 128) - 64;
        w   = {5'd0, 5'($urandom_range(0, 31)), 6'd0, off[15:0]};
        if (r < 55)      rand_instr = {6'h08, 26'($urandom)};
        else if (r < 65) rand_instr = {6'h04, w[25:0]};
        else if (r < 75) rand_instr = {6'h05, w[25:0]};
        else if (r < 82) rand_instr = {6'h02, 26'(off)};
        else if (r < 87) rand_instr = {6'h03, 26'(off)};
        else if (r < 91) rand_instr = 32'h4800_0000;
        else if (r < 94) rand_instr = 32'h4C00_0000;
        else if (r < 96) rand_instr = HALT_W;
        else             rand_instr = $urandom;
    endfunction

    initial begin
        reset = 1; stall = 0; rs1_zero = 0; rs1_val = 0;
        fill_mem();
        m_pc = RESET_PC; m_instr = NOP_W; m_pcid = 0; m_pc4 = 0;
        m_valid = 0; m_halted = 0; m_ids_known = 1;
        @(posedge clk);
        #1;
        cycle(1, 0, 0, 0);

        // Sequential fetch, BEQZ taken, then BEQZ not-taken into the JAL loop
        mem[0] = 32'h2001_0001; mem[1] = 32'h2002_0002; mem[2] = 32'h2003_0003;
        mem[4] = 32'h1020_0008; mem[7] = 32'h2007_0007; mem[8] = 32'h0FFF_FFF8;
        for (int i = 0; i < 10; i++) cycle(0, 0, 1, 0);
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 12; i++) cycle(0, 0, 0, 0);

        // JR to 0x40
        fill_mem();
        mem[1] = 32'h4800_0000;
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 32'h40);

        // BEQZ held in ID under a 3-cycle stall
        fill_mem();
        mem[2] = 32'h1020_0008;
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0);

        // Trap-halt with toggling stall, then reset recovery
        fill_mem();
        mem[2] = HALT_W;
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
        for (int i = 0; i < 14; i++) cycle(0, 1'($urandom_range(0, 1)), 0, 0);
        cycle(1, 1, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);

        // J to 0xFFFF_FFF8 and wrap through zero
        fill_mem();
        mem[0] = 32'h0BFF_FFF4;
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0);

        // Randomized programs with random hazards and occasional reset
        for (int run = 0; run < 6; run++) begin
            for (int i = 0; i < 256; i++) mem[i] = rand_instr();
            cycle(1, 0, 0, 0);
            for (int i = 0; i < 250; i++)
                cycle(1'($urandom_range(0, 99) == 0),
                      1'($urandom_range(0, 3) == 0),
                      1'($urandom_range(0, 1)),
                      32'($urandom_range(0, 1023)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
